// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

    localparam int DMEM_ADDR_W = 9;
    localparam int DMEM_DATA_W = 32;
    // Wide enough for any read latency in 1..7.
    localparam int LAT_CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } arb_state_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant logic, purely combinational.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic [1:0] o_grant,
    output logic       o_valid
);

    // On a tie the port that was not granted last time wins.
    always_comb begin
        o_grant = 2'b00;
        o_valid = |i_req;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = i_last_grant ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a single-port data memory between the core port (0) and the
// loader/debug port (1), with fixed-latency read sequencing.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W  = DMEM_ADDR_W,
    parameter int DATA_W  = DMEM_DATA_W,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    arb_state_t           r_state;
    arb_state_t           w_next;
    logic                 r_last;
    logic                 r_sel;
    logic                 r_we;
    logic                 r_err;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic [DATA_W-1:0]    r_rdata0;
    logic [DATA_W-1:0]    r_rdata1;
    logic [LAT_CNT_W-1:0] r_cnt;

    logic [1:0]           w_grant;
    logic                 w_valid;
    logic                 w_win_we;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [DATA_W-1:0]    w_win_wdata;
    logic                 w_misalign;
    logic                 w_last_beat;

    rr_arb2 u_rr_arb2 (
        .i_req        ({m1_req, m0_req}),
        .i_last_grant (r_last),
        .o_grant      (w_grant),
        .o_valid      (w_valid)
    );

    assign w_win_we    = w_grant[0] ? m0_we    : m1_we;
    assign w_win_addr  = w_grant[0] ? m0_addr  : m1_addr;
    assign w_win_wdata = w_grant[0] ? m0_wdata : m1_wdata;
    assign w_misalign  = |w_win_addr[1:0];
    assign w_last_beat = (r_cnt <= LAT_CNT_W'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; misaligned grants skip the memory entirely.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_valid) w_next = w_misalign ? RESP : ACCESS;
            ACCESS:  w_next = WAIT;
            WAIT:    if (w_last_beat) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Grant latching, latency counter and per-port read-data capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last   <= 1'b1;
            r_sel    <= 1'b0;
            r_we     <= 1'b0;
            r_err    <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
            r_cnt    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_valid) begin
                        r_sel   <= w_grant[1];
                        r_last  <= w_grant[1];
                        r_we    <= w_win_we;
                        r_err   <= w_misalign;
                        r_addr  <= w_win_addr;
                        r_wdata <= w_win_wdata;
                        // Writes and errors must return zero read data.
                        if (w_grant[1]) r_rdata1 <= '0;
                        else            r_rdata0 <= '0;
                    end
                end
                ACCESS: r_cnt <= LAT_CNT_W'(MEM_LAT);
                WAIT: begin
                    r_cnt <= r_cnt - 1'b1;
                    if (w_last_beat && !r_we) begin
                        if (r_sel) r_rdata1 <= mem_rdata;
                        else       r_rdata0 <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_read  = (r_state == ACCESS) && !r_we;
    assign mem_write = (r_state == ACCESS) &&  r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign busy      = (r_state != IDLE);
    assign m0_ack    = (r_state == RESP) && !r_sel;
    assign m1_ack    = (r_state == RESP) &&  r_sel;
    assign m0_err    = m0_ack && r_err;
    assign m1_err    = m1_ack && r_err;
    assign m0_rdata  = r_rdata0;
    assign m1_rdata  = r_rdata1;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-requester arbiter and access sequencer in front of the single-port data memory. It shares the memory between the core load/store port (port 0) and the loader/debug port (port 1), serialises their requests with round-robin fairness, and drives the memory read and write strobes with a fixed read latency. It returns the read data and a one-cycle acknowledge to the winning requester, and rejects misaligned word addresses without touching memory.

## Interface
Parameters:
- ADDR_W, 9: byte address width. Word index is addr[ADDR_W-1:2].
- DATA_W, 32: data width.
- MEM_LAT, 1: memory read latency in cycles after the strobe cycle. Legal range 1..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- m0_req, m1_req  in  1  request; held high until the matching ack.
- m0_we, m1_we  in  1  1 = write, 0 = read. Must be stable while req is high.
- m0_addr, m1_addr  in  ADDR_W  byte address. Must be stable while req is high.
- m0_wdata, m1_wdata  in  DATA_W  write data. Must be stable while req is high.
- m0_ack, m1_ack  out  1  one-cycle completion pulse.
- m0_err, m1_err  out  1  valid with ack; 1 = misaligned address, access not performed.
- m0_rdata, m1_rdata  out  DATA_W  read data, valid with ack.
- mem_read, mem_write  out  1  memory strobes.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the strobe cycle.
- busy  out  1  high in any state other than IDLE.

## Operation
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - No request pending: remain in IDLE.
  - Any request pending: select a winner and latch its we, addr and wdata.
  - Winner's addr[1:0] is nonzero: go to RESP with err=1. No strobe is issued.
  - Otherwise: go to ACCESS.
- ACCESS: lasts exactly one cycle.
  - mem_read is high for a read, mem_write is high for a write.
  - mem_addr and mem_wdata carry the latched values.
  - Load the wait counter with MEM_LAT and go to WAIT.
- WAIT: decrement the counter each cycle. In the cycle where the counter reaches 1:
  - capture mem_rdata into the winner's rdata register (reads only);
  - go to RESP.
  Writes also pass through WAIT, so read and write latency are identical.
- RESP: lasts one cycle.
  - Winner's ack=1; err is driven.
  - rdata holds the captured word; it is 0 for writes and for errors.
  - Go to IDLE.
- Arbitration is round-robin through a last_grant register.
  - Only one port requesting: that port wins.
  - Both ports requesting: the port other than last_grant wins.
  - last_grant updates on every grant, including error grants.
- A requester drops req, or presents its next request, on the edge after ack. IDLE samples req after that edge, so back-to-back requests from one port are legal.
- The loser's req stays pending and is granted on the next IDLE.
- Reset value of mem_addr, mem_wdata and the rdata registers is 0. They hold their values until overwritten.

## Timing
- Reset, asserted at any time, immediately forces:
  - state = IDLE, last_grant = 1 (port 0 wins the first tie);
  - every ack, err, mem_read, mem_write and busy = 0;
  - every address and data register = 0.
- An in-flight access is abandoned without an ack; the requester must reissue it.
- Normal latency (req high in IDLE at cycle 0): ACCESS at cycle 1, WAIT at cycles 2..1+MEM_LAT, ack at cycle 2+MEM_LAT. With MEM_LAT=1, ack is at cycle 3.
- Misaligned latency: ack with err at cycle 1.
- Sustained throughput is one access per 3+MEM_LAT cycles.
- A write is committed by the memory on the ACCESS cycle edge.
- ack and the strobes are registered outputs (state-decoded from registers); they have no combinational path from req.
- Requests arriving while busy are ignored until IDLE. The other port's ack is never asserted during the winner's RESP.

## Structure
- Package dmem_arb_pkg holds:
  - the state enum (IDLE, ACCESS, WAIT, RESP);
  - ADDR_W and DATA_W default constants;
  - the MEM_LAT counter width (3 bits).
- Sub-module rr_arb2 is combinational. Its inputs are two req bits and last_grant; its outputs are a one-hot grant and a valid. It is instantiated once.
- Everything else lives in dmem_arbiter: the FSM, latches, counter and per-port rdata registers.

## Test plan
- Single read, port 0, addr=0x010, mem_rdata=0x4 at the expected cycle, MEM_LAT=1. Required: mem_read high at cycle 1 only; m0_ack and m0_rdata=0x4 at cycle 3; m0_err=0.
- Single write, port 1, addr=0x020, wdata=0xDEADBEEF. Required: mem_write at cycle 1 with mem_addr=0x020 and mem_wdata=0xDEADBEEF; m1_ack at cycle 3; m1_rdata=0.
- Both ports requesting continuously after reset. Required: grants alternate 0,1,0,1; each port gets exactly one ack per 8 cycles.
- Port 0 addr=0x013. Required: no strobe; m0_ack=1 and m0_err=1 at cycle 1.
- rst pulsed during WAIT of a port 1 read. Required: strobes, busy and ack low immediately; no m1_ack; the reissued request completes normally.
- MEM_LAT=4 read. Required: ack at cycle 6; rdata equals mem_rdata as sampled at cycle 5.
